// File: rtl/instr_decoder_pkg.sv
// Shared types and constants for the instruction decoder: family indices, condition codes,
// fetch FSM states, NZCV bit positions and the family decode function.
package instr_decoder_pkg;

  localparam logic [3:0] FAM_DP_REG  = 4'd0;
  localparam logic [3:0] FAM_DP_IMM  = 4'd1;
  localparam logic [3:0] FAM_MUL     = 4'd2;
  localparam logic [3:0] FAM_MULL    = 4'd3;
  localparam logic [3:0] FAM_SWP     = 4'd4;
  localparam logic [3:0] FAM_HALF    = 4'd5;
  localparam logic [3:0] FAM_BX      = 4'd6;
  localparam logic [3:0] FAM_LS_IMM  = 4'd7;
  localparam logic [3:0] FAM_LS_REG  = 4'd8;
  localparam logic [3:0] FAM_UNDEF   = 4'd9;
  localparam logic [3:0] FAM_LSM     = 4'd10;
  localparam logic [3:0] FAM_BRANCH  = 4'd11;
  localparam logic [3:0] FAM_CP_XFER = 4'd12;
  localparam logic [3:0] FAM_CDP     = 4'd13;
  localparam logic [3:0] FAM_CP_REG  = 4'd14;
  localparam logic [3:0] FAM_SWI     = 4'd15;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Priority order matters: BX and the multiply/swap/halfword encodings all live inside the 000 space.
  function automatic logic [3:0] decode_family(input logic [31:0] w);
    logic [3:0] fam;
    fam = FAM_DP_REG;
    if (w[27:4] == 24'h12FFF1) begin
      fam = FAM_BX;
    end else begin
      case (w[27:25])
        3'b000: begin
          if (w[7:4] == 4'b1001 && w[24:23] == 2'b00)
            fam = FAM_MUL;
          else if (w[7:4] == 4'b1001 && w[24:23] == 2'b01)
            fam = FAM_MULL;
          else if (w[7:4] == 4'b1001 && w[24:23] == 2'b10 && w[21:20] == 2'b00)
            fam = FAM_SWP;
          else if (w[7] && w[4] && w[6:5] != 2'b00)
            fam = FAM_HALF;
          else
            fam = FAM_DP_REG;
        end
        3'b001: fam = FAM_DP_IMM;
        3'b010: fam = FAM_LS_IMM;
        3'b011: fam = w[4] ? FAM_UNDEF : FAM_LS_REG;
        3'b100: fam = FAM_LSM;
        3'b101: fam = FAM_BRANCH;
        3'b110: fam = FAM_CP_XFER;
        default: begin
          if (w[24])
            fam = FAM_SWI;
          else
            fam = w[4] ? FAM_CP_REG : FAM_CDP;
        end
      endcase
    end
    return fam;
  endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Decoder bus: memory fetch handshake, flag write port and sequencer-facing decode outputs.
// undef_trap exists only when UNDEF_TRAP_EN is defined.
interface instr_decoder_if;
  logic        ld_ir;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        ld_cc;
  logic [3:0]  nzcv_in;
  logic        mem_req;
  logic        ir_valid;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic [15:0] family_bits;
  logic        COND;
  logic        L;
  logic        P;
  logic        A;
`ifdef UNDEF_TRAP_EN
  logic        undef_trap;

  modport master (
    output ld_ir, mem_data, mem_ready, ld_cc, nzcv_in,
    input  mem_req, ir_valid, ir, flags, family_bits, COND, L, P, A, undef_trap
  );
  modport slave (
    input  ld_ir, mem_data, mem_ready, ld_cc, nzcv_in,
    output mem_req, ir_valid, ir, flags, family_bits, COND, L, P, A, undef_trap
  );
`else
  modport master (
    output ld_ir, mem_data, mem_ready, ld_cc, nzcv_in,
    input  mem_req, ir_valid, ir, flags, family_bits, COND, L, P, A
  );
  modport slave (
    input  ld_ir, mem_data, mem_ready, ld_cc, nzcv_in,
    output mem_req, ir_valid, ir, flags, family_bits, COND, L, P, A
  );
`endif
endinterface

// File: rtl/instr_decoder_cond_eval.sv
// Combinational ARMv4 condition check of a 4-bit condition field against NZCV.
module instr_decoder_cond_eval
  import instr_decoder_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Fetch-side instruction decoder: fetch FSM, IR, NZCV flags and one-hot family decode for the sequencer.
// UNDEF_TRAP_EN adds undef_trap for undefined and coprocessor families.
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter logic [31:0] RESET_IR    = 32'hE1A00000
) (
  input  logic            clk,
  input  logic            rst,
  instr_decoder_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] fam_q, fam_d;
  logic        latch;
  logic        valid;
  logic        cond_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= RESET_IR;
      flags_q <= RESET_FLAGS;
      fam_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      fam_q   <= fam_d;
    end
  end

  // ld_ir during FETCH and mem_ready outside FETCH fall through with no effect.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      IDLE:  if (bus.ld_ir) state_d = FETCH;
      FETCH: begin
        if (bus.mem_ready) begin
          state_d = HOLD;
          latch   = 1'b1;
        end
      end
      HOLD:  if (bus.ld_ir) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ir_d    = ir_q;
    fam_d   = fam_q;
    flags_d = flags_q;
    if (latch) begin
      ir_d  = bus.mem_data;
      fam_d = 16'h0001 << decode_family(bus.mem_data);
    end
    if (bus.ld_cc)
      flags_d = bus.nzcv_in;
  end

  instr_decoder_cond_eval u_cond_eval (
    .cond_i (ir_q[31:28]),
    .nzcv_i (flags_q),
    .pass_o (cond_pass)
  );

  assign valid           = (state_q == HOLD);
  assign bus.mem_req     = (state_q == FETCH);
  assign bus.ir_valid    = valid;
  assign bus.ir          = ir_q;
  assign bus.flags       = flags_q;
  assign bus.family_bits = valid ? fam_q : 16'h0000;
  assign bus.COND        = valid && cond_pass;
  assign bus.L           = ir_q[20];
  assign bus.P           = ir_q[24];
  assign bus.A           = ir_q[21];

`ifdef UNDEF_TRAP_EN
  assign bus.undef_trap = valid && (fam_q[FAM_UNDEF] || fam_q[FAM_CP_XFER] ||
                                    fam_q[FAM_CDP]   || fam_q[FAM_CP_REG]);
`endif

endmodule
